// File: rtl/pseudo_spi_rx_pkg.sv
// Shared pseudo SPI definitions: default link widths, bit order, and the TX/RX state codes.
package pseudo_spi_rx_pkg;

  localparam int unsigned MemDataWidth    = 8;
  localparam int unsigned MemAddrWidth    = 9;
  localparam int unsigned ReservedDataLen = 8;

  // The link always shifts the least significant bit first.
  localparam bit SpiLsbFirst = 1'b1;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxLoad  = 2'd1,
    TxShift = 2'd2,
    TxDone  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle = 2'd0,
    RxRecv = 2'd1,
    RxDone = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pseudo_spi_edge_det.sv
// Registers the pseudo SPI strobes and produces single-cycle rising-edge pulses.
module pseudo_spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sclk1,
  input  logic sclk2,
  input  logic lat,
  output logic sclk1_rise,
  output logic sclk2_rise,
  output logic lat_rise
);

  logic sclk1_q, sclk2_q, lat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk1_q <= 1'b0;
      sclk2_q <= 1'b0;
      lat_q   <= 1'b0;
    end else begin
      sclk1_q <= sclk1;
      sclk2_q <= sclk2;
      lat_q   <= lat;
    end
  end

  assign sclk1_rise = sclk1 & ~sclk1_q;
  assign sclk2_rise = sclk2 & ~sclk2_q;
  assign lat_rise   = lat & ~lat_q;

endmodule

// File: rtl/pseudo_spi_rx.sv
// Pseudo SPI receive stage: rebuilds bytes from the SCLK1/SCLK2/LAT strobe stream and
// writes DATA_LEN consecutive bytes into the SRAM starting at ADDR_BGN+1.
module pseudo_spi_rx
  import pseudo_spi_rx_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = MemDataWidth,
  parameter int unsigned MEMORY_ADDR_WIDTH = MemAddrWidth,
  parameter int unsigned RESERVED_DATA_LEN = ReservedDataLen
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SCLK1,
  input  logic                         SCLK2,
  input  logic                         LAT,
  input  logic                         SPI_SI,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         FRM_ERR,
  output logic                         spi_is_done
);

  localparam int unsigned BitCntW = $clog2(MEMORY_DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(MEMORY_DATA_WIDTH - 1);

  rx_state_e                    state;
  logic [MEMORY_DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BitCntW-1:0]           bit_cnt;
  logic [RESERVED_DATA_LEN-1:0] byte_cnt, len_q;
  logic [MEMORY_ADDR_WIDTH-1:0] base_q;
  logic                         wr_pend;
  logic                         armed;
  logic                         sclk1_rise, sclk2_rise, lat_rise;
  logic                         sample;

  pseudo_spi_edge_det u_edge_det (
    .clk        (CLK),
    .rst        (RST),
    .sclk1      (SCLK1),
    .sclk2      (SCLK2),
    .lat        (LAT),
    .sclk1_rise (sclk1_rise),
    .sclk2_rise (sclk2_rise),
    .lat_rise   (lat_rise)
  );

  always_comb begin
    if (SpiLsbFirst) begin
      shreg_nxt = {SPI_SI, shreg[MEMORY_DATA_WIDTH-1:1]};
    end else begin
      shreg_nxt = {shreg[MEMORY_DATA_WIDTH-2:0], SPI_SI};
    end
  end

  // A sample needs an SCLK2 edge since the previous sample, or one in the same cycle.
  assign sample = sclk1_rise & (armed | sclk2_rise);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RxIdle;
      CEN         <= 1'b1;
      WEN         <= 1'b1;
      A           <= '0;
      D           <= '0;
      FRM_ERR     <= 1'b0;
      spi_is_done <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wr_pend     <= 1'b0;
      armed       <= 1'b1;
    end else begin
      CEN <= 1'b1;
      WEN <= 1'b1;
      unique case (state)
        RxIdle: begin
          len_q       <= DATA_LEN;
          base_q      <= ADDR_BGN;
          FRM_ERR     <= 1'b0;
          bit_cnt     <= '0;
          byte_cnt    <= '0;
          wr_pend     <= 1'b0;
          armed       <= 1'b1;
          spi_is_done <= 1'b0;
          if (BGN) begin
            if (DATA_LEN == '0) begin
              state       <= RxDone;
              spi_is_done <= 1'b1;
            end else begin
              state <= RxRecv;
            end
          end
        end

        RxRecv: begin
          if (!BGN) begin
            state   <= RxIdle;
            wr_pend <= 1'b0;
            bit_cnt <= '0;
          end else begin
            // Fire the pending write first so a byte completing this cycle still schedules.
            if (wr_pend) begin
              CEN      <= 1'b0;
              WEN      <= 1'b0;
              A        <= base_q + MEMORY_ADDR_WIDTH'(1) + MEMORY_ADDR_WIDTH'(byte_cnt);
              byte_cnt <= byte_cnt + RESERVED_DATA_LEN'(1);
              wr_pend  <= 1'b0;
            end
            if (sclk2_rise) begin
              armed <= 1'b1;
            end
            if (lat_rise && bit_cnt != '0) begin
              FRM_ERR <= 1'b1;
              bit_cnt <= '0;
            end else if (sample) begin
              armed <= 1'b0;
              shreg <= shreg_nxt;
              if (bit_cnt == LastBit) begin
                bit_cnt <= '0;
                D       <= shreg_nxt;
                wr_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BitCntW'(1);
              end
            end
            // CEN low means this is the write cycle; byte_cnt already counts it.
            if (!CEN && byte_cnt == len_q) begin
              state       <= RxDone;
              spi_is_done <= 1'b1;
            end
          end
        end

        RxDone: begin
          spi_is_done <= 1'b1;
          if (!BGN) begin
            state       <= RxIdle;
            spi_is_done <= 1'b0;
          end
        end

        default: begin
          state <= RxIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pseudo_spi_rx.sv
// Randomised bench for pseudo_spi_rx: a byte-list model predicts every SRAM write.
module tb_pseudo_spi_rx;

  logic       CLK = 1'b0;
  logic       RST, BGN, SCLK1, SCLK2, LAT, SPI_SI;
  logic [8:0] ADDR_BGN;
  logic [7:0] DATA_LEN;
  logic       CEN, WEN, FRM_ERR, spi_is_done;
  logic [8:0] A;
  logic [7:0] D;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] got_a[$];
  logic [7:0] got_d[$];
  logic [8:0] exp_a[$];
  logic [7:0] exp_d[$];

  always #5 CLK = ~CLK;

  pseudo_spi_rx dut (
    .CLK         (CLK),
    .RST         (RST),
    .BGN         (BGN),
    .ADDR_BGN    (ADDR_BGN),
    .DATA_LEN    (DATA_LEN),
    .SCLK1       (SCLK1),
    .SCLK2       (SCLK2),
    .LAT         (LAT),
    .SPI_SI      (SPI_SI),
    .CEN         (CEN),
    .WEN         (WEN),
    .A           (A),
    .D           (D),
    .FRM_ERR     (FRM_ERR),
    .spi_is_done (spi_is_done)
  );

  // Every cycle with both strobes low is one SRAM write.
  always @(negedge CLK) begin
    if (RST === 1'b0 && CEN === 1'b0 && WEN === 1'b0) begin
      got_a.push_back(A);
      got_d.push_back(D);
    end
  end

  // Reference: byte i of the transfer lands at (base + 1 + i) mod 512.
  task automatic build_model(input logic [8:0] base, input logic [7:0] bytes[$]);
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < bytes.size(); i++) begin
      exp_a.push_back(9'((int'(base) + 1 + i) % 512));
      exp_d.push_back(bytes[i]);
    end
  endtask

  task automatic start_xfer(input logic [8:0] base, input logic [7:0] len);
    @(negedge CLK);
    ADDR_BGN = base;
    DATA_LEN = len;
    BGN      = 1'b1;
    got_a.delete();
    got_d.delete();
  endtask

  task automatic end_xfer();
    @(negedge CLK);
    BGN = 1'b0;
    LAT = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // One bit: SCLK1 pulse, SCLK2 pulse, idle slot (optionally LAT). A glitch adds a spurious
  // SCLK1 pulse carrying the inverted bit before SCLK2, which must be ignored.
  task automatic send_bit(input logic b, input bit lat_after, input int gap, input bit glitch);
    @(negedge CLK);
    LAT = 1'b0; SPI_SI = b; SCLK1 = 1'b1;
    if (glitch) begin
      @(negedge CLK);
      SCLK1 = 1'b0;
      repeat (2) @(negedge CLK);
      @(negedge CLK);
      SCLK1 = 1'b1; SPI_SI = ~b;
    end
    @(negedge CLK);
    SCLK1 = 1'b0; SCLK2 = 1'b1;
    @(negedge CLK);
    SCLK2 = 1'b0;
    @(negedge CLK);
    LAT = lat_after;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; BGN = 1'b0; SCLK1 = 1'b0; SCLK2 = 1'b0; LAT = 1'b0; SPI_SI = 1'b0;
    ADDR_BGN = '0; DATA_LEN = '0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({CEN, WEN, A, D, FRM_ERR, spi_is_done} !== {1'b1, 1'b1, 9'h0, 8'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got CEN=%b WEN=%b A=%h D=%h ERR=%b done=%b, want 1 1 000 00 0 0",
               CEN, WEN, A, D, FRM_ERR, spi_is_done);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_stream(input string name, input logic [8:0] base,
                             input logic [7:0] bytes[$], input bit rnd);
    build_model(base, bytes);
    start_xfer(base, 8'(bytes.size()));
    for (int k = 0; k < bytes.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        send_bit(bytes[k][i], rnd ? (i == 7 && $urandom_range(0, 1) == 1) : (i == 7),
                 rnd ? int'($urandom_range(0, 2)) : 0, rnd && $urandom_range(0, 3) == 0);
      end
    end
    for (int i = 0; i < 40 && spi_is_done !== 1'b1; i++) @(negedge CLK);
    vectors++;
    if (spi_is_done !== 1'b1 || CEN !== 1'b1 || FRM_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end: got done=%b CEN=%b ERR=%b, want 1 1 0",
               name, spi_is_done, CEN, FRM_ERR);
    end
    vectors++;
    if (got_a.size() != exp_a.size()) begin
      miscompares++;
      $display("FAIL %s write count: got %0d, want %0d", name, got_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      vectors++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        miscompares++;
        $display("FAIL %s write %0d: got A=%h D=%h, want A=%h D=%h",
                 name, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
    end_xfer();
    vectors++;
    if (spi_is_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: got done=%b, want 0", name, spi_is_done);
    end
  endtask

  // Last bit driven by hand to pin the 2-cycle write latency and the done timing.
  task automatic test_latency();
    logic [8:0] base;
    logic [7:0] b;
    base = 9'($urandom);
    b    = 8'($urandom);
    start_xfer(base, 8'd1);
    for (int i = 0; i < 7; i++) send_bit(b[i], 1'b0, 0, 1'b0);
    @(negedge CLK);
    SPI_SI = b[7]; SCLK1 = 1'b1;
    @(negedge CLK);
    SCLK1 = 1'b0; SCLK2 = 1'b1;
    vectors++;
    if (CEN !== 1'b1) begin
      miscompares++;
      $display("FAIL latency early: got CEN=%b, want 1", CEN);
    end
    @(negedge CLK);
    SCLK2 = 1'b0;
    vectors++;
    if (CEN !== 1'b0 || WEN !== 1'b0 || A !== 9'((int'(base) + 1) % 512) || D !== b) begin
      miscompares++;
      $display("FAIL latency write: got CEN=%b WEN=%b A=%h D=%h, want 0 0 %h %h",
               CEN, WEN, A, D, 9'((int'(base) + 1) % 512), b);
    end
    @(negedge CLK);
    vectors++;
    if (CEN !== 1'b1 || spi_is_done !== 1'b1) begin
      miscompares++;
      $display("FAIL latency after: got CEN=%b done=%b, want 1 1", CEN, spi_is_done);
    end
    end_xfer();
  endtask

  task automatic test_zero_len();
    start_xfer(9'($urandom), 8'd0);
    repeat (2) @(negedge CLK);
    vectors++;
    if (spi_is_done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_len done: got %b, want 1", spi_is_done);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (got_a.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len writes: got %0d, want 0", got_a.size());
    end
    end_xfer();
    vectors++;
    if (spi_is_done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len idle: got done=%b, want 0", spi_is_done);
    end
  endtask

  task automatic test_frame_err();
    logic [8:0] base;
    logic [7:0] b;
    base = 9'($urandom);
    b    = 8'hC2;
    start_xfer(base, 8'd1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 0, 1'b0);
    @(negedge CLK);
    LAT = 1'b1;
    @(negedge CLK);
    LAT = 1'b0;
    vectors++;
    if (FRM_ERR !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err flag: got %b, want 1", FRM_ERR);
    end
    for (int i = 0; i < 8; i++) send_bit(b[i], i == 7, 0, 1'b0);
    for (int i = 0; i < 20 && spi_is_done !== 1'b1; i++) @(negedge CLK);
    vectors++;
    if (got_a.size() != 1 || spi_is_done !== 1'b1 || FRM_ERR !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err end: got writes=%0d done=%b ERR=%b, want 1 1 1",
               got_a.size(), spi_is_done, FRM_ERR);
    end else begin
      vectors++;
      if (got_a[0] !== 9'((int'(base) + 1) % 512) || got_d[0] !== b) begin
        miscompares++;
        $display("FAIL frame_err data: got A=%h D=%h, want A=%h D=%h",
                 got_a[0], got_d[0], 9'((int'(base) + 1) % 512), b);
      end
    end
    end_xfer();
    vectors++;
    if (FRM_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_err clear: got %b, want 0", FRM_ERR);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    start_xfer(9'($urandom), 8'd3);
    for (int i = 0; i < 8; i++) send_bit(b0[i], i == 7, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(b1[i], 1'b0, 0, 1'b0);
    @(negedge CLK);
    BGN = 1'b0;
    repeat (4) @(negedge CLK);
    vectors++;
    if (got_d.size() != 1 || spi_is_done !== 1'b0 || CEN !== 1'b1) begin
      miscompares++;
      $display("FAIL abort: got writes=%0d done=%b CEN=%b, want 1 0 1",
               got_d.size(), spi_is_done, CEN);
    end else begin
      vectors++;
      if (got_d[0] !== b0) begin
        miscompares++;
        $display("FAIL abort data: got D=%h, want %h", got_d[0], b0);
      end
    end
  endtask

  task automatic test_reset_in_write();
    logic [7:0] b;
    b = 8'($urandom) | 8'h80;
    start_xfer(9'($urandom_range(1, 510)), 8'd2);
    for (int i = 0; i < 7; i++) send_bit(b[i], 1'b0, 0, 1'b0);
    @(negedge CLK);
    SPI_SI = b[7]; SCLK1 = 1'b1;
    @(negedge CLK);
    SCLK1 = 1'b0; SCLK2 = 1'b1;
    @(negedge CLK);
    SCLK2 = 1'b0;
    vectors++;
    if (CEN !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_write setup: got CEN=%b, want 0", CEN);
    end
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({CEN, WEN, A, D, FRM_ERR, spi_is_done} !== {1'b1, 1'b1, 9'h0, 8'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_write: got CEN=%b WEN=%b A=%h D=%h ERR=%b done=%b, want 1 1 000 00 0 0",
               CEN, WEN, A, D, FRM_ERR, spi_is_done);
    end
    BGN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [15:0] words[7];
    test_reset();

    q = '{8'hAB, 8'h00, 8'h00, 8'h3C};
    test_stream("basic", 9'h1FF, q, 1'b0);

    q = '{8'h11, 8'h22, 8'h33};
    test_stream("wrap", 9'h1FD, q, 1'b0);

    test_latency();
    test_zero_len();
    test_frame_err();
    test_abort();
    test_reset_in_write();

    words = '{16'h00AB, 16'h3C00, 16'h0500, 16'h9E3D, 16'hD7C3, 16'h7A58, 16'hC201};
    q.delete();
    for (int i = 0; i < 7; i++) begin
      q.push_back(words[i][7:0]);
      q.push_back(words[i][15:8]);
    end
    test_stream("back_to_back", 9'($urandom), q, 1'b0);

    for (int t = 0; t < 6; t++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) q.push_back(8'($urandom));
      test_stream("random", 9'($urandom), q, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
